// File: rtl/silencer_sched_pkg.sv
// silencer_sched_pkg
//   Shared types and constants for the silencer sequencing controller.
//   - sched_state_t : handshake FSM states
//   - CYCLE_S_MIN   : smallest period (ticks) the scheduler will run
//   - STEP_MIN      : smallest step forwarded to the silencer
//   - OVERRUN_MAX   : saturation value of the overrun counter
package silencer_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_LOW  = 2'd2,
        ST_WAIT_HIGH = 2'd3
    } sched_state_t;

    localparam int CYCLE_S_MIN = 2;
    localparam int STEP_MIN    = 1;
    localparam int OVERRUN_MAX = 255;

    // A period of 0 or 1 tick would make the counter compare against
    // 0xFFFF or fire every tick, so short periods are raised to the minimum.
    function automatic logic [15:0] clamp_cycle(input logic [15:0] cycle);
        return (cycle < 16'(CYCLE_S_MIN)) ? 16'(CYCLE_S_MIN) : cycle;
    endfunction

endpackage

// File: rtl/silencer_period_cnt.sv
// silencer_period_cnt
//   Tick detector plus period counter. A tick is any cycle in which SYS_TIME
//   differs from its registered copy; TRIGGER fires combinationally on the
//   tick that completes a period of CYCLE_S ticks.
//   Ports:
//     CLK      in   system clock
//     RST      in   asynchronous active-high reset
//     SYS_TIME in   64-bit free-running system time
//     EN       in   count enable; low holds the counter at 0, no TRIGGER
//     CYCLE_S  in   active period length in ticks
//     CLR      in   forces the counter to 0 (new period applied)
//     TRIGGER  out  period boundary, combinational
module silencer_period_cnt (
    input  logic        CLK,
    input  logic        RST,
    input  logic [63:0] SYS_TIME,
    input  logic        EN,
    input  logic [15:0] CYCLE_S,
    input  logic        CLR,
    output logic        TRIGGER
);

    logic [63:0] sys_time_reg;
    logic        time_valid_reg;
    logic [15:0] pcnt_reg;
    logic [15:0] pcnt_next;
    logic        tick;
    logic        period_end;

    // time_valid_reg masks the first cycle after reset, when sys_time_reg
    // still holds its reset value rather than a real sample.
    assign tick       = time_valid_reg && (SYS_TIME != sys_time_reg);
    assign period_end = (pcnt_reg == (CYCLE_S - 16'd1));
    assign TRIGGER    = EN && tick && period_end;

    always_comb begin
        pcnt_next = pcnt_reg;
        if (!EN || CLR) begin
            pcnt_next = 16'd0;
        end else if (tick) begin
            pcnt_next = period_end ? 16'd0 : (pcnt_reg + 16'd1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sys_time_reg   <= 64'd0;
            time_valid_reg <= 1'b0;
            pcnt_reg       <= 16'd0;
        end else begin
            sys_time_reg   <= SYS_TIME;
            time_valid_reg <= 1'b1;
            pcnt_reg       <= pcnt_next;
        end
    end

endmodule

// File: rtl/silencer_sched.sv
// silencer_sched
//   Sequencing controller for the silencer datapath. Splits SYS_TIME ticks
//   into periods, issues one START per period, double-buffers STEP/CYCLE_S
//   so new values only appear on a period boundary, and supervises the
//   DONE handshake (overrun count, sticky timeout flag).
//   Ports:
//     CLK, RST            clock, asynchronous active-high reset
//     SYS_TIME            free-running time, a change is a tick
//     EN                  scheduler enable
//     CFG_WE/CFG_STEP/CFG_CYCLE_S  pending configuration write
//     DONE                silencer completion, low while computing
//     STEP, CYCLE_S       active configuration to the silencer
//     START               one-cycle calculation request
//     CFG_PENDING         written configuration not yet applied
//     BUSY                handshake in progress
//     OVERRUN_CNT         saturating count of skipped periods
//     ACK_ERR             sticky handshake timeout flag
module silencer_sched
    import silencer_sched_pkg::*;
#(
    parameter int WIDTH           = 13,
    parameter int DEFAULT_STEP    = 10,
    parameter int DEFAULT_CYCLE_S = 4096,
    parameter int ACK_TIMEOUT     = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [63:0]      SYS_TIME,
    input  logic             EN,
    input  logic             CFG_WE,
    input  logic [WIDTH-1:0] CFG_STEP,
    input  logic [15:0]      CFG_CYCLE_S,
    input  logic             DONE,
    output logic [WIDTH-1:0] STEP,
    output logic [15:0]      CYCLE_S,
    output logic             START,
    output logic             CFG_PENDING,
    output logic             BUSY,
    output logic [7:0]       OVERRUN_CNT,
    output logic             ACK_ERR
);

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

    sched_state_t     state_reg, state_next;
    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next, to_cnt_inc;
    logic [WIDTH-1:0] step_reg, step_next;
    logic [15:0]      cycle_reg, cycle_next;
    logic [WIDTH-1:0] pend_step_reg, pend_step_next;
    logic [15:0]      pend_cycle_reg, pend_cycle_next;
    logic             pend_valid_reg, pend_valid_next;
    logic [7:0]       overrun_reg, overrun_next;
    logic             ack_err_reg, ack_err_next;
    logic             trigger;
    logic             apply;
    logic [WIDTH-1:0] cfg_step_clamped;

    silencer_period_cnt u_period_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .SYS_TIME (SYS_TIME),
        .EN       (EN),
        .CYCLE_S  (cycle_reg),
        .CLR      (apply),
        .TRIGGER  (trigger)
    );

    // Pending values are only consumed by a trigger that actually starts a
    // calculation; an overrun trigger leaves them pending.
    assign apply            = trigger && (state_reg == ST_IDLE) && pend_valid_reg;
    assign cfg_step_clamped = (CFG_STEP == '0) ? WIDTH'(STEP_MIN) : CFG_STEP;
    assign to_cnt_inc       = to_cnt_reg + TO_W'(1);

    // Shadow registers. A write in the same cycle as an apply lands in the
    // pending slot after the old pending values are taken, so the flag stays set.
    always_comb begin
        step_next       = step_reg;
        cycle_next      = cycle_reg;
        pend_step_next  = pend_step_reg;
        pend_cycle_next = pend_cycle_reg;
        pend_valid_next = pend_valid_reg;
        if (apply) begin
            step_next       = pend_step_reg;
            cycle_next      = pend_cycle_reg;
            pend_valid_next = 1'b0;
        end
        if (CFG_WE) begin
            pend_step_next  = cfg_step_clamped;
            pend_cycle_next = clamp_cycle(CFG_CYCLE_S);
            pend_valid_next = 1'b1;
        end
    end

    // Handshake FSM and error/overrun bookkeeping.
    always_comb begin
        state_next   = state_reg;
        to_cnt_next  = to_cnt_reg;
        ack_err_next = ack_err_reg;
        overrun_next = overrun_reg;
        case (state_reg)
            ST_IDLE: begin
                if (trigger) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                to_cnt_next = '0;
                state_next  = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!DONE) begin
                    state_next = ST_WAIT_HIGH;
                end else if (to_cnt_inc == TO_W'(ACK_TIMEOUT)) begin
                    state_next   = ST_IDLE;
                    ack_err_next = 1'b1;
                end else begin
                    to_cnt_next = to_cnt_inc;
                end
            end
            ST_WAIT_HIGH: begin
                if (DONE) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (trigger && (state_reg != ST_IDLE) && (overrun_reg != 8'(OVERRUN_MAX))) begin
            overrun_next = overrun_reg + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= ST_IDLE;
            to_cnt_reg     <= '0;
            step_reg       <= WIDTH'(DEFAULT_STEP);
            cycle_reg      <= 16'(DEFAULT_CYCLE_S);
            pend_step_reg  <= WIDTH'(DEFAULT_STEP);
            pend_cycle_reg <= 16'(DEFAULT_CYCLE_S);
            pend_valid_reg <= 1'b0;
            overrun_reg    <= 8'd0;
            ack_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            to_cnt_reg     <= to_cnt_next;
            step_reg       <= step_next;
            cycle_reg      <= cycle_next;
            pend_step_reg  <= pend_step_next;
            pend_cycle_reg <= pend_cycle_next;
            pend_valid_reg <= pend_valid_next;
            overrun_reg    <= overrun_next;
            ack_err_reg    <= ack_err_next;
        end
    end

    assign STEP        = step_reg;
    assign CYCLE_S     = cycle_reg;
    assign START       = (state_reg == ST_START);
    assign BUSY        = (state_reg != ST_IDLE);
    assign CFG_PENDING = pend_valid_reg;
    assign OVERRUN_CNT = overrun_reg;
    assign ACK_ERR     = ack_err_reg;

endmodule

// File: tb/tb_silencer_sched.sv
// tb_silencer_sched
//   Directed bench for silencer_sched. Inputs change and outputs are sampled
//   on the falling clock edge. A small silencer model drops DONE for
//   model_n cycles after each START (or never, when never_drop is set).
module tb_silencer_sched;

    localparam int WIDTH = 13;

    logic             CLK;
    logic             RST;
    logic [63:0]      SYS_TIME;
    logic             EN;
    logic             CFG_WE;
    logic [WIDTH-1:0] CFG_STEP;
    logic [15:0]      CFG_CYCLE_S;
    logic             DONE;
    logic [WIDTH-1:0] STEP;
    logic [15:0]      CYCLE_S;
    logic             START;
    logic             CFG_PENDING;
    logic             BUSY;
    logic [7:0]       OVERRUN_CNT;
    logic             ACK_ERR;

    int tests = 0;
    int fails = 0;
    int tick_en = 0;
    int model_n = 3;
    int never_drop = 0;
    int model_left = 0;

    silencer_sched #(
        .WIDTH           (WIDTH),
        .DEFAULT_STEP    (10),
        .DEFAULT_CYCLE_S (16),
        .ACK_TIMEOUT     (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SYS_TIME    (SYS_TIME),
        .EN          (EN),
        .CFG_WE      (CFG_WE),
        .CFG_STEP    (CFG_STEP),
        .CFG_CYCLE_S (CFG_CYCLE_S),
        .DONE        (DONE),
        .STEP        (STEP),
        .CYCLE_S     (CYCLE_S),
        .START       (START),
        .CFG_PENDING (CFG_PENDING),
        .BUSY        (BUSY),
        .OVERRUN_CNT (OVERRUN_CNT),
        .ACK_ERR     (ACK_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Silencer model: DONE low during the model_n cycles after START.
    initial begin
        DONE = 1'b1;
        forever begin
            @(negedge CLK);
            if (START) begin
                model_left = never_drop ? 0 : model_n;
            end else if (model_left > 0) begin
                DONE = 1'b0;
                model_left--;
            end else begin
                DONE = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("[TB] check %-16s observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: land on the falling edge, then advance time if ticking.
    task automatic adv();
        @(negedge CLK);
        if (tick_en != 0) SYS_TIME = SYS_TIME + 64'd1;
    endtask

    // Advance until START is seen; n is the number of cycles taken
    // (equals max when the bound expired).
    task automatic wait_start(input int max, output int n);
        n = 0;
        do begin
            adv();
            n++;
        end while (!START && n < max);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_step"},  64'(STEP), 64'd10);
        chk({tag, "_cycle"}, 64'(CYCLE_S), 64'd16);
        chk({tag, "_start"}, 64'(START), 64'd0);
        chk({tag, "_pend"},  64'(CFG_PENDING), 64'd0);
        chk({tag, "_busy"},  64'(BUSY), 64'd0);
        chk({tag, "_ovr"},   64'(OVERRUN_CNT), 64'd0);
        chk({tag, "_ackerr"}, 64'(ACK_ERR), 64'd0);
    endtask

    initial begin
        int n;
        int bw;
        RST = 1'b1; SYS_TIME = 64'd0; EN = 1'b1;
        CFG_WE = 1'b0; CFG_STEP = '0; CFG_CYCLE_S = 16'd0;

        // Reset state
        adv(); adv();
        RST = 1'b0;
        chk_reset_vals("rst");
        adv();
        tick_en = 1;

        // First period after reset: 16 ticks, START visible one cycle later
        wait_start(40, n);
        chk("first_start_lat", 64'(n), 64'd17);
        chk("first_step", 64'(STEP), 64'd10);
        chk("first_busy", 64'(BUSY), 64'd1);
        bw = 1;
        do begin
            adv();
            if (BUSY) bw++;
        end while (BUSY && bw < 50);
        chk("busy_width", 64'(bw), 64'd5);
        chk("basic_ovr", 64'(OVERRUN_CNT), 64'd0);

        // Atomic apply: write mid-period, values appear only with START
        CFG_WE = 1'b1; CFG_STEP = 13'd200; CFG_CYCLE_S = 16'd8;
        adv();
        CFG_WE = 1'b0;
        chk("apply_pend_set", 64'(CFG_PENDING), 64'd1);
        chk("apply_step_hold", 64'(STEP), 64'd10);
        repeat (9) adv();
        chk("apply_pre_start", 64'(START), 64'd0);
        chk("apply_pre_step", 64'(STEP), 64'd10);
        adv();
        chk("apply_start", 64'(START), 64'd1);
        chk("apply_step", 64'(STEP), 64'd200);
        chk("apply_cycle", 64'(CYCLE_S), 64'd8);
        chk("apply_pend_clr", 64'(CFG_PENDING), 64'd0);
        wait_start(40, n);
        chk("period8_lat", 64'(n), 64'd8);

        // Clamp and coincidence: second write lands on the trigger cycle
        adv(); adv();
        CFG_WE = 1'b1; CFG_STEP = 13'd300; CFG_CYCLE_S = 16'd6;
        adv();
        CFG_WE = 1'b0;
        repeat (4) adv();
        CFG_WE = 1'b1; CFG_STEP = 13'd0; CFG_CYCLE_S = 16'd1;
        adv();
        CFG_WE = 1'b0;
        chk("coin_start", 64'(START), 64'd1);
        chk("coin_step_old", 64'(STEP), 64'd300);
        chk("coin_cycle_old", 64'(CYCLE_S), 64'd6);
        chk("coin_pend_kept", 64'(CFG_PENDING), 64'd1);
        wait_start(40, n);
        chk("period6_lat", 64'(n), 64'd6);
        chk("clamp_step", 64'(STEP), 64'd1);
        chk("clamp_cycle", 64'(CYCLE_S), 64'd2);
        chk("clamp_pend_clr", 64'(CFG_PENDING), 64'd0);
        // Period 2 with a 5-cycle handshake: two triggers skipped
        wait_start(40, n);
        chk("short_lat", 64'(n), 64'd6);
        chk("short_ovr", 64'(OVERRUN_CNT), 64'd2);

        // Timeout: silencer never drops DONE
        adv();
        CFG_WE = 1'b1; CFG_STEP = 13'd7; CFG_CYCLE_S = 16'd20;
        never_drop = 1;
        adv();
        CFG_WE = 1'b0;
        wait_start(40, n);
        chk("to_start_lat", 64'(n), 64'd4);
        chk("to_step", 64'(STEP), 64'd7);
        chk("to_cycle", 64'(CYCLE_S), 64'd20);
        chk("to_ovr", 64'(OVERRUN_CNT), 64'd4);
        repeat (8) adv();
        chk("to_ackerr_pre", 64'(ACK_ERR), 64'd0);
        chk("to_busy_pre", 64'(BUSY), 64'd1);
        adv();
        chk("to_ackerr", 64'(ACK_ERR), 64'd1);
        chk("to_idle", 64'(BUSY), 64'd0);
        wait_start(40, n);
        chk("to_next_start", 64'(n), 64'd11);

        // Mid-handshake reset while waiting for DONE to rise
        adv();
        chk("start_width", 64'(START), 64'd0);
        never_drop = 0;
        model_n = 3;
        wait_start(40, n);
        chk("pre_rst_lat", 64'(n), 64'd19);
        adv(); adv();
        chk("pre_rst_busy", 64'(BUSY), 64'd1);
        tick_en = 0;
        RST = 1'b1;
        adv();
        chk_reset_vals("midrst");
        RST = 1'b0;
        CFG_WE = 1'b1; CFG_STEP = 13'd5; CFG_CYCLE_S = 16'd4;
        model_n = 2;
        adv();
        CFG_WE = 1'b0;
        chk("post_rst_pend", 64'(CFG_PENDING), 64'd1);
        tick_en = 1;
        wait_start(40, n);
        chk("post_rst_lat", 64'(n), 64'd17);
        chk("post_rst_step", 64'(STEP), 64'd5);
        chk("post_rst_cycle", 64'(CYCLE_S), 64'd4);

        // Overrun: every other trigger skipped, count saturates at 255
        wait_start(40, n);
        chk("ovr_lat", 64'(n), 64'd8);
        chk("ovr_one", 64'(OVERRUN_CNT), 64'd1);
        wait_start(40, n);
        chk("ovr_two", 64'(OVERRUN_CNT), 64'd2);
        repeat (253) wait_start(40, n);
        chk("ovr_255", 64'(OVERRUN_CNT), 64'd255);
        repeat (45) wait_start(40, n);
        chk("ovr_sat_lat", 64'(n), 64'd8);
        chk("ovr_sat", 64'(OVERRUN_CNT), 64'd255);
        chk("ovr_ackerr", 64'(ACK_ERR), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
